// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Data TCM tag width, burst length and FSM states.
package cpu_pkg;

  localparam int TAG_WIDTH      = 9;
  localparam int DTCM_BURST_LEN = 4;

  typedef enum logic {
    IDLE,
    BURST
  } dtcm_state_t;

endpackage

// File: rtl/cpu_dtcm_ram.sv
// Single-port byte-enable RAM for the data TCM.
// Registered read returns old data on read-during-write.
module cpu_dtcm_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/cpu_dtcm.sv
// Data TCM responder: singles, strobed writes, wrapping bursts.
// Two-cycle read latency through RAM and output registers.
module cpu_dtcm
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BURST_LEN  = DTCM_BURST_LEN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dtcm_request,
  output logic                 dtcm_ready,
  input  logic                 dtcm_write,
  input  logic [31:0]          dtcm_address,
  input  logic                 dtcm_burst,
  input  logic [3:0]           dtcm_wstrb,
  input  logic [31:0]          dtcm_wdata,
  output logic                 dtcm_rvalid,
  output logic [31:0]          dtcm_rdata,
  output logic [31:0]          dtcm_raddr,
  output logic [TAG_WIDTH-1:0] dtcm_rtag
);

  localparam int CW = $clog2(BURST_LEN);

  dtcm_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          base_q, base_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 ready_q;

  logic                 accept;
  logic                 rd_en;
  logic                 wr_en;
  logic [31:0]          iss_addr;
  logic [TAG_WIDTH-1:0] iss_tag;

  logic                 v1_q;
  logic [31:0]          a1_q;
  logic [TAG_WIDTH-1:0] t1_q;
  logic [31:0]          ram_rdata;

  assign dtcm_ready = ready_q & ~reset;
  assign accept     = dtcm_ready & dtcm_request;

  always_comb begin
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    iss_addr = {dtcm_address[31:2], 2'b00};
    iss_tag  = dtcm_wdata[TAG_WIDTH-1:0];
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    tag_d    = tag_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dtcm_write) begin
            wr_en = 1'b1;
          end else begin
            rd_en = 1'b1;
            if (dtcm_burst) begin
              state_d = BURST;
              cnt_d   = CW'(1);
              base_d  = iss_addr;
              tag_d   = iss_tag;
            end
          end
        end
      end
      BURST: begin
        // Low word bits wrap inside the aligned burst block.
        rd_en    = 1'b1;
        iss_tag  = tag_q;
        iss_addr = {base_q[31:CW+2],
                    base_q[CW+1:2] + cnt_q,
                    2'b00};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(BURST_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  cpu_dtcm_ram #(
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clock),
    .en_i   (rd_en | wr_en),
    .we_i   (wr_en),
    .be_i   (dtcm_wstrb),
    .addr_i (iss_addr[ADDR_WIDTH+1:2]),
    .wdata_i(dtcm_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      tag_q       <= '0;
      ready_q     <= 1'b1;
      v1_q        <= 1'b0;
      a1_q        <= '0;
      t1_q        <= '0;
      dtcm_rvalid <= 1'b0;
      dtcm_rdata  <= '0;
      dtcm_raddr  <= '0;
      dtcm_rtag   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      ready_q     <= (state_d == IDLE);
      v1_q        <= rd_en;
      a1_q        <= iss_addr;
      t1_q        <= iss_tag;
      dtcm_rvalid <= v1_q;
      if (v1_q) begin
        dtcm_rdata <= ram_rdata;
        dtcm_raddr <= a1_q;
        dtcm_rtag  <= t1_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dtcm.sv
// Randomized bench for cpu_dtcm against a transaction-level model.
// Model: word array plus a queue of expected beats with due cycles.
module tb_cpu_dtcm;

  localparam int AW = 12;
  localparam int BL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        dtcm_request;
  logic        dtcm_ready;
  logic        dtcm_write;
  logic [31:0] dtcm_address;
  logic        dtcm_burst;
  logic [3:0]  dtcm_wstrb;
  logic [31:0] dtcm_wdata;
  logic        dtcm_rvalid;
  logic [31:0] dtcm_rdata;
  logic [31:0] dtcm_raddr;
  logic [8:0]  dtcm_rtag;

  cpu_dtcm #(
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dtcm_request(dtcm_request),
    .dtcm_ready  (dtcm_ready),
    .dtcm_write  (dtcm_write),
    .dtcm_address(dtcm_address),
    .dtcm_burst  (dtcm_burst),
    .dtcm_wstrb  (dtcm_wstrb),
    .dtcm_wdata  (dtcm_wdata),
    .dtcm_rvalid (dtcm_rvalid),
    .dtcm_rdata  (dtcm_rdata),
    .dtcm_raddr  (dtcm_raddr),
    .dtcm_rtag   (dtcm_rtag)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
    logic [31:0] data;
    logic [8:0]  tag;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem[int unsigned];
  int unsigned cyc;
  int unsigned busy_until;
  bit          in_rst;
  int          nchk;
  int          nerr;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) & ((1 << AW) - 1);
  endfunction

  function automatic logic [31:0] mrd(input int unsigned i);
    return mem.exists(i) ? mem[i] : 32'h0;
  endfunction

  task automatic sample();
    beat_t b;
    check("ready", dtcm_ready,
          (!in_rst && cyc >= busy_until));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      b = exp_q.pop_front();
      check("rvalid", dtcm_rvalid, 1'b1);
      check("rdata", dtcm_rdata, b.data);
      check("raddr", dtcm_raddr, b.addr);
      check("rtag", dtcm_rtag, b.tag);
    end else begin
      check("rvalid_idle", dtcm_rvalid, 1'b0);
    end
  endtask

  // One bus cycle: drive, check outputs, model acceptance, advance.
  task automatic step(input bit rst, input bit req,
                      input bit wr, input logic [31:0] a,
                      input bit bu, input logic [3:0] st,
                      input logic [31:0] wd);
    logic [31:0] cur;
    logic [31:0] w;
    beat_t b;
    reset        = rst;
    dtcm_request = req;
    dtcm_write   = wr;
    dtcm_address = a;
    dtcm_burst   = bu;
    dtcm_wstrb   = st;
    dtcm_wdata   = wd;
    in_rst       = rst;
    #1;
    sample();
    if (!rst && req && cyc >= busy_until) begin
      if (wr) begin
        cur = mrd(widx(a));
        for (int k = 0; k < 4; k++)
          if (st[k]) cur[8*k +: 8] = wd[8*k +: 8];
        mem[widx(a)] = cur;
      end else if (bu) begin
        for (int i = 0; i < BL; i++) begin
          w = (a >> 2);
          w = (w & ~32'(BL - 1)) | ((w + 32'(i)) & 32'(BL - 1));
          b.due  = cyc + 2 + i;
          b.addr = w << 2;
          b.data = mrd(widx(w << 2));
          b.tag  = wd[8:0];
          exp_q.push_back(b);
        end
        busy_until = cyc + BL;
      end else begin
        b.due  = cyc + 2;
        b.addr = {a[31:2], 2'b00};
        b.data = mrd(widx(a));
        b.tag  = wd[8:0];
        exp_q.push_back(b);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      busy_until = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    step(0, 1, 1, a, 0, s, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [8:0] t,
                    input bit bu);
    step(0, 1, 0, a, bu, 4'h0, {23'h0, t});
  endtask

  initial begin
    int r;
    logic [31:0] a;
    nchk = 0;
    nerr = 0;
    cyc = 0;
    busy_until = 0;
    in_rst = 1;
    reset = 1;
    dtcm_request = 0;
    dtcm_write = 0;
    dtcm_address = 0;
    dtcm_burst = 0;
    dtcm_wstrb = 0;
    dtcm_wdata = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    in_rst = 0;
    #1;
    check("rst_rdata", dtcm_rdata, 32'h0);
    check("rst_raddr", dtcm_raddr, 32'h0);
    check("rst_rtag", dtcm_rtag, 9'h0);

    wr(32'h100, 32'hDEADBEEF, 4'hF);
    rd(32'h100, 9'h1A5, 0);
    idle(3);

    wr(32'h40, 32'h11223344, 4'hF);
    wr(32'h40, 32'hAABBCCDD, 4'b0101);
    rd(32'h40, 9'h033, 0);
    idle(3);

    for (int i = 0; i < 4; i++)
      wr(32'h200 + 32'(4 * i), 32'(i), 4'hF);
    rd(32'h208, 9'h007, 1);
    for (int i = 0; i < 5; i++)
      rd(32'h200, 9'h055, 0);
    idle(4);

    wr(32'h80, 32'hCAFEF00D, 4'hF);
    rd(32'h80, 9'h011, 0);
    wr(32'h84, 32'h01234567, 4'h0);
    for (int i = 0; i < 4; i++)
      rd(32'h100, 9'(i + 1), 0);
    idle(3);

    rd(32'h204, 9'h0AA, 1);
    idle(3);
    step(1, 0, 0, 32'h0, 0, 4'h0, 32'h0);
    idle(3);

    wr(32'h4000, 32'h5A5A1234, 4'hF);
    rd(32'h0000, 9'h0C3, 0);
    idle(3);

    for (int i = 0; i < 64; i++)
      wr(32'(i * 4), $urandom, 4'hF);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 63) << 2)
        | ($urandom_range(0, 3) << 14)
        | $urandom_range(0, 3);
      if (r < 1)
        step(1, 0, 0, a, 0, 4'h0, 32'h0);
      else if (r < 25)
        idle(1);
      else if (r < 55)
        wr(a, $urandom, 4'($urandom));
      else if (r < 85)
        rd(a, 9'($urandom), 0);
      else
        rd(a, 9'($urandom), 1);
    end
    idle(BL + 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
